// File: rtl/load_store_unit.sv
// Memory stage: non-memory results pass to write-back in one cycle; loads/stores take a
// two-state IDLE/ACCESS handshake with alignment checks, lane steering and a wait timeout.
module load_store_unit #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  in_alucode,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   input  logic        in_rd_we,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        exc_valid,
   output logic [1:0]  exc_code,
   output logic [31:0] exc_addr
);
   localparam logic [5:0] ALU_LB  = 6'd16;
   localparam logic [5:0] ALU_LH  = 6'd17;
   localparam logic [5:0] ALU_LW  = 6'd18;
   localparam logic [5:0] ALU_LBU = 6'd19;
   localparam logic [5:0] ALU_LHU = 6'd20;
   localparam logic [5:0] ALU_SB  = 6'd21;
   localparam logic [5:0] ALU_SH  = 6'd22;
   localparam logic [5:0] ALU_SW  = 6'd23;

   localparam logic [1:0] EXC_LD  = 2'b01;
   localparam logic [1:0] EXC_ST  = 2'b10;
   localparam logic [1:0] EXC_TMO = 2'b11;

   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [5:0]    r_op;
   logic [31:0]   r_addr;
   logic [4:0]    r_rd;
   logic          r_rd_we;

   logic          w_is_load;
   logic          w_is_store;
   logic [1:0]    w_size;
   logic          w_misaligned;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic          w_r_store;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_ld_data;

   assign in_ready = rst_n && (r_state == S_IDLE);

   // w_size: 0 byte, 1 halfword, 2 word
   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_size     = 2'd2;
      case (in_alucode)
         ALU_LB, ALU_LBU: begin w_is_load  = 1'b1; w_size = 2'd0; end
         ALU_LH, ALU_LHU: begin w_is_load  = 1'b1; w_size = 2'd1; end
         ALU_LW:          begin w_is_load  = 1'b1; w_size = 2'd2; end
         ALU_SB:          begin w_is_store = 1'b1; w_size = 2'd0; end
         ALU_SH:          begin w_is_store = 1'b1; w_size = 2'd1; end
         ALU_SW:          begin w_is_store = 1'b1; w_size = 2'd2; end
         default: ;
      endcase
      w_misaligned = ((w_size == 2'd1) && in_addr[0]) ||
                     ((w_size == 2'd2) && (in_addr[1:0] != 2'b00));
      w_be    = 4'b0000;
      w_wdata = 32'd0;
      if (w_is_store) begin
         case (w_size)
            2'd0:    begin w_be = 4'b0001 << in_addr[1:0]; w_wdata = {4{in_wdata[7:0]}};  end
            2'd1:    begin w_be = 4'b0011 << in_addr[1:0]; w_wdata = {2{in_wdata[15:0]}}; end
            default: begin w_be = 4'b1111;                 w_wdata = in_wdata;            end
         endcase
      end
   end

   always_comb begin
      w_r_store = (r_op == ALU_SB) || (r_op == ALU_SH) || (r_op == ALU_SW);
      case (r_addr[1:0])
         2'd0:    w_byte = mem_rdata[7:0];
         2'd1:    w_byte = mem_rdata[15:8];
         2'd2:    w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half    = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      w_ld_data = mem_rdata;
      case (r_op)
         ALU_LB:  w_ld_data = {{24{w_byte[7]}}, w_byte};
         ALU_LBU: w_ld_data = {24'd0, w_byte};
         ALU_LH:  w_ld_data = {{16{w_half[15]}}, w_half};
         ALU_LHU: w_ld_data = {16'd0, w_half};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_op      <= 6'd0;
         r_addr    <= 32'd0;
         r_rd      <= 5'd0;
         r_rd_we   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
         wb_valid  <= 1'b0;
         wb_we     <= 1'b0;
         wb_rd     <= 5'd0;
         wb_data   <= 32'd0;
         exc_valid <= 1'b0;
         exc_code  <= 2'd0;
         exc_addr  <= 32'd0;
      end else begin
         wb_valid  <= 1'b0;
         exc_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (!(w_is_load || w_is_store)) begin
                     wb_valid <= 1'b1;
                     wb_we    <= in_rd_we && (in_rd != 5'd0);
                     wb_rd    <= in_rd;
                     wb_data  <= in_addr;
                  end else if (w_misaligned) begin
                     exc_valid <= 1'b1;
                     exc_code  <= w_is_store ? EXC_ST : EXC_LD;
                     exc_addr  <= in_addr;
                  end else begin
                     r_state   <= S_ACCESS;
                     r_cnt     <= '0;
                     r_op      <= in_alucode;
                     r_addr    <= in_addr;
                     r_rd      <= in_rd;
                     r_rd_we   <= in_rd_we;
                     mem_req   <= 1'b1;
                     mem_we    <= w_is_store;
                     mem_addr  <= {in_addr[31:2], 2'b00};
                     mem_be    <= w_be;
                     mem_wdata <= w_wdata;
                  end
               end
            end
            S_ACCESS: begin
               // an ack on the final wait cycle wins over the timeout
               if (mem_ack) begin
                  r_state  <= S_IDLE;
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  mem_be   <= 4'd0;
                  wb_valid <= 1'b1;
                  wb_rd    <= r_rd;
                  wb_we    <= w_r_store ? 1'b0 : (r_rd_we && (r_rd != 5'd0));
                  wb_data  <= w_r_store ? 32'd0 : w_ld_data;
               end else if (r_cnt == CNT_LAST) begin
                  r_state   <= S_IDLE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_be    <= 4'd0;
                  exc_valid <= 1'b1;
                  exc_code  <= EXC_TMO;
                  exc_addr  <= r_addr;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
